// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between N client channels, the round-robin memory arbiter and one memory port.
// Handshake: a client holds req/we/addr/wdata until its one-cycle gnt pulse; a memory transfer happens in any cycle with mem_req && mem_ready; memory returns exactly one mem_rvalid per transfer, in transfer order.
interface mem_arbiter_rr_if #(
   parameter int N_CH = 4,
   parameter int AW   = 48,
   parameter int DW   = 64
);
   logic [N_CH-1:0]    req;
   logic [N_CH-1:0]    we;
   logic [N_CH*AW-1:0] addr;
   logic [N_CH*DW-1:0] wdata;
   logic [N_CH-1:0]    gnt;
   logic [N_CH-1:0]    valid;
   logic [DW-1:0]      rdata;
   logic               mem_req;
   logic               mem_ready;
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic               mem_rvalid;
   logic [DW-1:0]      mem_rdata;
   logic               err;

   modport slave (
      input  req, we, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
      output gnt, valid, rdata, mem_req, mem_we, mem_addr, mem_wdata, err
   );

   modport master (
      output req, we, addr, wdata, mem_ready, mem_rvalid, mem_rdata,
      input  gnt, valid, rdata, mem_req, mem_we, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin memory arbiter: one registered request slot, credit-limited outstanding
// requests, and an ID FIFO that steers each in-order memory response back to its issuing channel.
module mem_arbiter_rr #(
   parameter int N_CH    = 4,
   parameter int AW      = 48,
   parameter int DW      = 64,
   parameter int MAX_OUT = 4
) (
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_rr_if.slave bus
);
   localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW  = $clog2(MAX_OUT + 1);
   localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wr_q, wr_d;
   logic [PW-1:0]   rd_q, rd_d;
   logic [IDW-1:0]  fifo_q [MAX_OUT];
   logic [IDW-1:0]  fifo_d [MAX_OUT];
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [N_CH-1:0] valid_q, valid_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;

   logic            slot_free;
   logic            credit_ok;
   logic            found;
   logic            grant;
   logic            pop;
   logic [IDW-1:0]  win;
   logic [N_CH-1:0] gnt;
   int              idx;

   function automatic logic [PW-1:0] ring_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
   endfunction

   // Winner is the first requester strictly after the last winner, wrapping at N_CH.
   always_comb begin
      slot_free = !mem_req_q || bus.mem_ready;
      credit_ok = cnt_q < CW'(MAX_OUT);
      found     = 1'b0;
      win       = '0;
      idx       = 0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = (int'(ptr_q) + k) % N_CH;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
      grant = slot_free && credit_ok && found;
      gnt   = grant ? (N_CH'(1) << win) : '0;
   end

   always_comb begin
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      fifo_d      = fifo_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = '0;
      rdata_d     = rdata_q;
      err_d       = err_q;
      // FIFO occupancy always equals cnt, so cnt doubles as the empty test.
      pop         = bus.mem_rvalid && (cnt_q != '0);

      if (grant) begin
         mem_req_d    = 1'b1;
         mem_we_d     = bus.we[win];
         mem_addr_d   = bus.addr[int'(win)*AW +: AW];
         mem_wdata_d  = bus.wdata[int'(win)*DW +: DW];
         ptr_d        = win;
         fifo_d[wr_q] = win;
         wr_d         = ring_inc(wr_q);
      end else if (slot_free) begin
         mem_req_d = 1'b0;
      end

      if (pop) begin
         valid_d = N_CH'(1) << fifo_q[rd_q];
         rdata_d = bus.mem_rdata;
         rd_d    = ring_inc(rd_q);
      end

      if (bus.mem_rvalid && (cnt_q == '0)) begin
         err_d = 1'b1;
      end

      if (grant && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !grant) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= IDW'(N_CH - 1);
         cnt_q       <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         for (int i = 0; i < MAX_OUT; i++) begin
            fifo_q[i] <= '0;
         end
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         valid_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         fifo_q      <= fifo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign bus.gnt       = gnt;
   assign bus.valid     = valid_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr: directed scenarios plus randomized traffic, checked
// against a queue-based reference model and an end-to-end channel/data scoreboard.
module tb_mem_arbiter_rr;
   localparam int N_CH    = 4;
   localparam int AW      = 48;
   localparam int DW      = 64;
   localparam int MAX_OUT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_rr_if #(.N_CH(N_CH), .AW(AW), .DW(DW)) bus ();

   mem_arbiter_rr #(.N_CH(N_CH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // ---------------- stimulus controls ----------------
   bit          auto_en      = 1'b0;
   int          req_pct      = 0;
   int          withdraw_pct = 0;
   int          ready_pct    = 100;
   int          lat_min      = 1;
   int          lat_max      = 1;
   int          resp_budget  = -1;
   bit          data_ovr_en  = 1'b0;
   logic [DW-1:0] data_ovr   = '0;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      int            due;
   } resp_t;
   resp_t resp_q[$];

   // ---------------- scoreboard ----------------
   int            sb_ch_q[$];
   bit            sb_we_q[$];
   logic [DW-1:0] exp_q[$];
   int            gnt_log[$];

   // ---------------- reference model ----------------
   int            m_ptr;
   int            m_ch_q[$];
   bit            m_we_q[$];
   bit            m_slot_v;
   logic          m_slot_we;
   logic [AW-1:0] m_slot_addr;
   logic [DW-1:0] m_slot_wdata;
   logic [N_CH-1:0] m_valid;
   bit            m_valid_we;
   logic [DW-1:0] m_rdata;
   bit            m_err;

   logic [N_CH-1:0] o_gnt, o_valid;
   logic [DW-1:0]   o_rdata, o_mem_wdata;
   logic [AW-1:0]   o_mem_addr;
   logic            o_mem_req, o_mem_we, o_err;

   function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
      return data_ovr_en ? data_ovr : {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
   endfunction

   function automatic logic [AW-1:0] ch_addr(input int c);
      return bus.addr[c*AW +: AW];
   endfunction

   task automatic model_reset();
      m_ptr      = N_CH - 1;
      m_ch_q.delete();
      m_we_q.delete();
      m_slot_v   = 1'b0;
      m_valid    = '0;
      m_valid_we = 1'b0;
      m_rdata    = '0;
      m_err      = 1'b0;
   endtask

   task automatic model_step();
      bit free;
      int w;
      int h;
      free = !m_slot_v || bus.mem_ready;
      w    = -1;
      if (free && m_ch_q.size() < MAX_OUT) begin
         for (int k = 1; k <= N_CH; k++) begin
            if (w < 0 && bus.req[(m_ptr + k) % N_CH]) w = (m_ptr + k) % N_CH;
         end
      end
      check_eq("gnt", o_gnt, (w >= 0) ? (64'd1 << w) : 64'd0);
      check_eq("mem_req", o_mem_req, m_slot_v);
      if (m_slot_v) begin
         check_eq("mem_addr", o_mem_addr, m_slot_addr);
         check_eq("mem_we", o_mem_we, m_slot_we);
         check_eq("mem_wdata", o_mem_wdata, m_slot_wdata);
      end
      check_eq("valid", o_valid, m_valid);
      if (m_valid != 0 && !m_valid_we) check_eq("rdata", o_rdata, m_rdata);
      check_eq("err", o_err, m_err);

      m_valid = '0;
      if (bus.mem_rvalid) begin
         if (m_ch_q.size() > 0) begin
            h          = m_ch_q.pop_front();
            m_valid_we = m_we_q.pop_front();
            m_valid    = N_CH'(1) << h;
            m_rdata    = bus.mem_rdata;
         end else begin
            m_err = 1'b1;
         end
      end
      if (w >= 0) begin
         m_ch_q.push_back(w);
         m_we_q.push_back(bus.we[w]);
         m_slot_v     = 1'b1;
         m_slot_we    = bus.we[w];
         m_slot_addr  = ch_addr(w);
         m_slot_wdata = bus.wdata[w*DW +: DW];
         m_ptr        = w;
      end else if (free) begin
         m_slot_v = 1'b0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_chan(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req[c]           = 1'b1;
      bus.we[c]            = w;
      bus.addr[c*AW +: AW] = a;
      bus.wdata[c*DW +: DW] = d;
   endtask

   task automatic new_req(input int c);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      set_chan(c, ($urandom_range(0, 3) == 0), AW'(r), {$urandom(), $urandom()});
   endtask

   task automatic drive_next();
      resp_t e;
      for (int c = 0; c < N_CH; c++) begin
         if (o_gnt[c]) bus.req[c] = 1'b0;
         if (rst && auto_en) begin
            if (bus.req[c] && $urandom_range(0, 99) < withdraw_pct) bus.req[c] = 1'b0;
            else if (!bus.req[c] && $urandom_range(0, 99) < req_pct) new_req(c);
         end
      end
      bus.mem_ready  = ($urandom_range(0, 99) < ready_pct);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = {$urandom(), $urandom()};
      if (rst && resp_q.size() > 0 && resp_q[0].due <= cyc && resp_budget != 0) begin
         e = resp_q.pop_front();
         bus.mem_rvalid = 1'b1;
         if (!e.we) bus.mem_rdata = data_for(e.addr);
         if (resp_budget > 0) resp_budget--;
      end
   endtask

   // One clock: sample and check at negedge, then drive the next cycle's inputs after posedge.
   task automatic cycle();
      int gi;
      int ch;
      bit w;
      logic [DW-1:0] d;
      @(negedge clk);
      o_gnt       = bus.gnt;
      o_valid     = bus.valid;
      o_rdata     = bus.rdata;
      o_mem_req   = bus.mem_req;
      o_mem_we    = bus.mem_we;
      o_mem_addr  = bus.mem_addr;
      o_mem_wdata = bus.mem_wdata;
      o_err       = bus.err;
      if (!rst) begin
         check_eq("rst_gnt", o_gnt, 0);
         check_eq("rst_valid", o_valid, 0);
         check_eq("rst_rdata", o_rdata, 0);
         check_eq("rst_mem_req", o_mem_req, 0);
         check_eq("rst_mem_we", o_mem_we, 0);
         check_eq("rst_mem_addr", o_mem_addr, 0);
         check_eq("rst_mem_wdata", o_mem_wdata, 0);
         check_eq("rst_err", o_err, 0);
         model_reset();
      end else begin
         model_step();
         if (o_gnt != 0) begin
            gi = 0;
            for (int c = 0; c < N_CH; c++) if (o_gnt[c]) gi = c;
            gnt_log.push_back(gi);
            sb_ch_q.push_back(gi);
            sb_we_q.push_back(bus.we[gi]);
            exp_q.push_back(data_for(ch_addr(gi)));
         end
         if (o_valid != 0) begin
            if (sb_ch_q.size() == 0) begin
               check_eq("sb_unexpected_valid", o_valid, 0);
            end else begin
               ch = sb_ch_q.pop_front();
               w  = sb_we_q.pop_front();
               d  = exp_q.pop_front();
               check_eq("sb_valid_ch", o_valid, 64'd1 << ch);
               if (!w) check_eq("sb_rdata", o_rdata, d);
            end
         end
         if (bus.mem_req && bus.mem_ready) begin
            resp_q.push_back('{we: bus.mem_we, addr: bus.mem_addr,
                               due: cyc + $urandom_range(lat_min, lat_max)});
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_next();
   endtask

   task automatic reset_dut();
      rst            = 1'b0;
      auto_en        = 1'b0;
      bus.req        = '0;
      bus.mem_rvalid = 1'b0;
      resp_q.delete();
      sb_ch_q.delete();
      sb_we_q.delete();
      exp_q.delete();
      gnt_log.delete();
      model_reset();
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      int nv;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      rst            = 1'b0;
      bus.req        = '0;
      bus.we         = '0;
      bus.addr       = '0;
      bus.wdata      = '0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      model_reset();

      // Reset values, then idle with no requests.
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("idle_mem_req", o_mem_req, 0);
      end

      // Single read from channel 2, memory answers two cycles after acceptance.
      reset_dut();
      ready_pct = 100; bus.mem_ready = 1'b1;
      lat_min = 2; lat_max = 2;
      data_ovr_en = 1'b1; data_ovr = 64'hDEADBEEF_CAFEF00D;
      set_chan(2, 1'b0, 48'h1000, '0);
      cycle();
      check_eq("rd_gnt", o_gnt, 4'b0100);
      cycle();
      check_eq("rd_mem_req", o_mem_req, 1);
      check_eq("rd_mem_addr", o_mem_addr, 48'h1000);
      cycle();
      cycle();
      cycle();
      check_eq("rd_valid", o_valid, 4'b0100);
      check_eq("rd_rdata", o_rdata, 64'hDEADBEEF_CAFEF00D);
      data_ovr_en = 1'b0;

      // Fairness: all channels request back-to-back, response the cycle after acceptance.
      reset_dut();
      ready_pct = 100; bus.mem_ready = 1'b1;
      lat_min = 1; lat_max = 1;
      for (int c = 0; c < N_CH; c++) new_req(c);
      auto_en = 1'b1; req_pct = 100; withdraw_pct = 0;
      for (int i = 0; i < 20; i++) cycle();
      check_eq("fair_log_len", gnt_log.size() >= 8, 1);
      for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
         check_eq($sformatf("fair_order%0d", i), gnt_log[i], i % N_CH);
      end

      // Backpressure: channels 1 and 3 with mem_ready low for five cycles.
      reset_dut();
      ready_pct = 0; bus.mem_ready = 1'b0;
      a1 = 48'h1111_0040; d1 = 64'h1111_2222_3333_4444;
      set_chan(1, 1'b1, a1, d1);
      set_chan(3, 1'b0, 48'h3333_0080, '0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (o_gnt != 0) n++;
         if (i == 0) check_eq("bp_first_gnt", o_gnt, 4'b0010);
         if (i >= 1) begin
            check_eq("bp_hold_req", o_mem_req, 1);
            check_eq("bp_hold_addr", o_mem_addr, a1);
            check_eq("bp_hold_wdata", o_mem_wdata, d1);
         end
      end
      check_eq("bp_grant_count", n, 1);
      ready_pct = 100; bus.mem_ready = 1'b1;
      cycle();
      check_eq("bp_ch3_on_ready", o_gnt, 4'b1000);
      check_eq("bp_slot_at_release", o_mem_addr, a1);

      // Credit limit: no responses until one is released.
      reset_dut();
      ready_pct = 100; bus.mem_ready = 1'b1;
      lat_min = 1; lat_max = 1; resp_budget = 0;
      for (int c = 0; c < N_CH; c++) new_req(c);
      auto_en = 1'b1; req_pct = 100;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (o_gnt != 0) n++;
      end
      check_eq("credit_grants", n, MAX_OUT);
      resp_budget = 1;
      cycle();
      check_eq("credit_stall", o_gnt, 0);
      cycle();
      check_eq("credit_full_with_rvalid", o_gnt, 0);
      cycle();
      check_eq("credit_regrant", o_gnt, 4'b0001);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (o_gnt != 0) n++;
      end
      check_eq("credit_single_regrant", n, 0);

      // Protocol error, then reset with requests in flight.
      reset_dut();
      resp_budget = -1; ready_pct = 100; bus.mem_ready = 1'b1;
      bus.mem_rvalid = 1'b1;
      cycle();
      cycle();
      check_eq("perr_err", o_err, 1);
      check_eq("perr_no_valid", o_valid, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("perr_sticky", o_err, 1);
      end
      resp_budget = 0;
      set_chan(0, 1'b0, 48'h0A00, '0);
      set_chan(1, 1'b0, 48'h0B00, '0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (o_gnt != 0) n++;
      end
      check_eq("perr_inflight", n, 2);
      reset_dut();
      resp_budget = -1; lat_min = 1; lat_max = 2;
      cycle();
      check_eq("perr_err_cleared", o_err, 0);
      set_chan(2, 1'b0, 48'h0C00, '0);
      n = 0; nv = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (i == 0) check_eq("resume_gnt", o_gnt, 4'b0100);
         if (o_gnt != 0) n++;
         if (o_valid != 0) nv++;
      end
      check_eq("resume_grants", n, 1);
      check_eq("resume_valids", nv, 1);

      // Randomized traffic with backpressure, variable latency and withdrawals.
      reset_dut();
      auto_en = 1'b1; req_pct = 40; withdraw_pct = 5;
      ready_pct = 70; lat_min = 1; lat_max = 5; resp_budget = -1;
      for (int i = 0; i < 600; i++) cycle();
      auto_en = 1'b0; ready_pct = 100; bus.req = '0;
      for (int i = 0; i < 40; i++) cycle();
      check_eq("sb_drained", sb_ch_q.size(), 0);
      check_eq("no_err_after_random", o_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-channel round-robin memory arbiter with in-order response routing. It is the successor to the single-client memory arbiter in `logos_core`. It sits between `N_CH` NTT engine DMA ports and the single host/DMA memory port, so several cores can share memory. It tracks outstanding requests by channel ID, limits them with a credit counter, and steers every returned response back to the channel that issued it.

## Interface
Parameters:
- `N_CH`, 4 — number of client channels (≥2)
- `AW`, 48 — address width
- `DW`, 64 — data width
- `MAX_OUT`, 4 — max granted-but-unanswered requests (≥1); also the ID FIFO depth
- `IDW`, derived = max(1, clog2(N_CH)) — channel ID width

Ports:
- `clk`  in  1  — single clock, rising edge
- `rst`  in  1  — asynchronous, active-low reset
- `req`  in  N_CH  — per-channel request, held until granted
- `we`  in  N_CH  — per-channel write enable
- `addr`  in  N_CH*AW  — per-channel address; channel i occupies [i*AW +: AW]
- `wdata`  in  N_CH*DW  — per-channel write data
- `gnt`  out  N_CH  — one-hot, one-cycle acceptance pulse
- `valid`  out  N_CH  — one-hot, one-cycle response pulse
- `rdata`  out  DW  — response data, shared by all channels, qualified by `valid`
- `mem_req`  out  1  — downstream request valid
- `mem_ready`  in  1  — downstream accepts when high with `mem_req`
- `mem_we`  out  1  — downstream write enable
- `mem_addr`  out  AW  — downstream address
- `mem_wdata`  out  DW  — downstream write data
- `mem_rvalid`  in  1  — downstream response, one per accepted request, in order
- `mem_rdata`  in  DW  — downstream read data; ignored for writes
- `err`  out  1  — sticky protocol-error flag

## Operation
- **Client rule:** a channel holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt[i]`. Dropping `req` before the grant withdraws the request.
- **Output slot:** one register holds `mem_req`, `mem_we`, `mem_addr` and `mem_wdata`.
- **Slot free condition:** the slot is free when `mem_req`=0, or when `mem_req`&&`mem_ready` in this cycle.
- **Grant condition:** a grant happens when the slot is free, `cnt` < `MAX_OUT` and `req` ≠ 0.
- **Grant selection:** `gnt` is combinational from `req`, `ptr`, `cnt` and the slot state. The winner is the first requesting channel searching from `ptr`+1 upward, modulo `N_CH`.
- **On a grant to channel w:**
  - the slot loads channel w's fields and `mem_req`=1;
  - w is pushed into the ID FIFO;
  - `ptr` becomes w;
  - `cnt` increments.
- **Slot clears:** when the slot is free and there is no grant, `mem_req` goes to 0.
- **On `mem_rvalid`:**
  - pop the FIFO head h;
  - next cycle, `valid[h]`=1 and `rdata` = `mem_rdata`;
  - `cnt` decrements.
- **Write responses:** writes also produce `valid`; `rdata` is don't-care for them.
- **Simultaneous grant and response:** `cnt` is unchanged, and the FIFO pushes and pops in the same cycle.
- **Response with empty FIFO:** if `mem_rvalid` arrives while the FIFO is empty, `err` is set and stays set until reset. There is no `valid` pulse and `cnt` is unchanged (it does not underflow).
- **Full credits:** at `cnt`=`MAX_OUT`, no grant is issued, even if a response arrives in the same cycle. The freed credit is usable the next cycle.
- **Channels not requesting:** they never receive `gnt`. Starvation is bounded at `N_CH`-1 grants to other channels.

## Timing
- **Reset values:** `gnt`=0, `valid`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err`=0. Internal: `ptr`=`N_CH`-1 (channel 0 wins first), `cnt`=0, FIFO empty.
- **Request latency:** `req` sampled in cycle t with a free slot gives `gnt` in t and `mem_req` high from t+1.
- **Response latency:** `mem_rvalid` in cycle r gives `valid` in r+1 (registered).
- **Throughput:** one grant per cycle while `mem_ready`=1 and credits are available.
- **Backpressure:** while `mem_ready`=0 the slot contents are held bit-stable and no new grant occurs.
- **Reset mid-operation:** asserting `rst` low clears all state immediately, including in-flight IDs. Any downstream responses that arrive after release hit an empty FIFO and set `err`.

## Test plan
- **Reset:** with `rst` low and then released, all outputs are 0. With `req`=0, `mem_req` stays 0.
- **Single read:** channel 2 requests a read at 0x1000 with `mem_ready`=1, and memory returns `mem_rdata`=0xDEADBEEF_CAFEF00D two cycles after acceptance. Required: `gnt`=0b0100 at t; `mem_req`=1 with `mem_addr`=0x1000 at t+1; `valid`=0b0100 with that `rdata` at t+4.
- **Fairness:** all 4 channels request continuously, `mem_ready`=1, each response returned the cycle after acceptance. Required: grant order 0,1,2,3,0,1,…; every `valid` matches its channel's address-tagged data.
- **Backpressure:** channels 1 and 3 request while `mem_ready`=0 for 5 cycles. Required: exactly one grant (to channel 1); the slot is stable for 5 cycles; channel 3 is granted in the cycle `mem_ready` rises.
- **Credit limit:** `MAX_OUT`=4, `mem_ready`=1, no responses. Required: exactly 4 grants, then stall. One `mem_rvalid` then gives exactly one further grant in the following cycle.
- **Protocol error and reset:** `mem_rvalid` with nothing outstanding sets `err`=1 with no `valid`, and `err` stays set. After that, an `rst` pulse with 2 requests in flight clears `err` and `cnt`, and normal grants resume.
